chronometer_display: RTL and testbench
======================================

Name: chronometer_display

Overview:
- Downstream consumer of the chronometer's `recordTimer` count.
- Converts the binary count to BCD with a sequential double-dabble engine: one bit per clock, restarting continuously.
- Latches the result and drives a time-multiplexed common-anode/cathode 7-segment display, with optional leading-zero blanking and overflow saturation.
- Feeds the board's display pins directly.

Parameters:
- FREQ_IN, 12000000: input clock frequency in Hz (integer).
- LIMIT_RECORD_TIMER, 1000: chronometer count limit. Input width IN_W = $clog2(LIMIT_RECORD_TIMER), which is 10 at default.
- DIGITS, 4: number of display digits (1..6).
- SCAN_HZ, 1000: refresh rate of each digit in Hz. Per-digit dwell SCAN_DIV = FREQ_IN/(SCAN_HZ*DIGITS) clocks; must be ≥1.
- ACTIVE_LOW, 1: 1 means segments and anodes are active-low; 0 means active-high.
- BLANK_LEADING, 1: 1 blanks leading zeros; digit 0 is always shown.

Ports:
- clk  input  1  system clock
- resetN  input  1  synchronous active-low reset, sampled on rising clk edge
- recordTimer  input  IN_W  binary count from the chronometer
- bcdDigits  output  4*DIGITS  latched BCD result; digit 0 in bits [3:0]
- bcdValid  output  1  one-cycle pulse when bcdDigits updates
- overflow  output  1  latched; high while the displayed value is saturated
- segments  output  7  segment drive {g,f,e,d,c,b,a}
- anodes  output  DIGITS  one-hot digit select; bit i drives digit i

Behaviour:
- **Reset** (resetN=0 at an edge):
  - State goes to IDLE; shift register, internal BCD, bcdDigits, scan prescaler and digit index are cleared.
  - bcdValid=0, overflow=0.
  - segments and anodes are all inactive: 7'h7F and all-ones when ACTIVE_LOW=1, zeros otherwise.
  - Reset mid-conversion aborts it; no bcdValid pulse is emitted.
- **Conversion FSM:**
  - Internal BCD width covers 2^IN_W-1: NB = ceil(IN_W*log10(2)) digits, computed as a localparam.
  - IDLE, 1 cycle: load recordTimer into the shift register, clear internal BCD, set bit counter to IN_W. Next state SHIFT.
  - SHIFT, IN_W cycles: every internal BCD digit ≥5 gets +3, then {bcd,shift} shifts left by 1. The counter decrements; at 1, go to DONE.
  - DONE, 1 cycle: on the edge leaving DONE, update bcdDigits and overflow, and pulse bcdValid high for exactly that following cycle. Next state IDLE.
  - Period is IN_W+2 cycles, back-to-back. recordTimer is sampled only in IDLE; changes during SHIFT are ignored until the next load.
  - After reset release, the first bcdValid appears after the (IN_W+2)th rising edge with resetN=1 (12th edge at default).
- **Overflow:**
  - If any internal BCD digit at index ≥ DIGITS is nonzero, bcdDigits is set to all 4'h9 and overflow=1.
  - Otherwise bcdDigits = the low DIGITS BCD digits and overflow=0.
  - overflow updates only with bcdValid.
- **Scan:**
  - Prescaler counts 0..SCAN_DIV-1. At SCAN_DIV-1 it wraps to 0 and the digit index advances: 0→1→…→DIGITS-1→0.
  - Anodes activate only digit[index]. Out of reset, digit 0 is active from the first edge with resetN=1.
  - segments and anodes are registered (one-cycle delay from index/bcdDigits) and change on the same edge, so there is no ghosting.
- **Decode**, active-high gfedcba:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Codes A–F are never produced; treat them as blank.
  - ACTIVE_LOW inverts both segments and anodes.
- **Blanking:**
  - With BLANK_LEADING=1, digit i>0 is blank (all segments off, anode still scanned) when it and every digit above it are zero.
  - Overflow disables blanking.
- Simultaneous bcdValid update and digit advance: the new bcdDigits value is used from the next registered output onward.

Test Plan:
- Reset: hold resetN=0 for 5 cycles with recordTimer=10'd512 → segments=7'h7F, anodes=4'hF, bcdDigits=16'h0000, bcdValid=0, overflow=0 throughout.
- Conversion latency: release reset with recordTimer=10'd987 → bcdValid is high only after edge 12, bcdDigits=16'h0987. Next pulse comes exactly 12 cycles later. Repeat for 0, 1 and 1023 (16'h1023).
- Scan order (FREQ_IN=16, SCAN_HZ=1, so SCAN_DIV=4), recordTimer=1023:
  - anodes cycle 1110→1101→1011→0111, 4 cycles each, wrapping.
  - segments 7'h30 ('3'), 7'h24 ('2'), 7'h40 ('0'), 7'h79 ('1').
- Blanking: recordTimer=5 → digit 0 segments=7'h12 ('5'); digits 1..3 segments=7'h7F.
  - recordTimer=500 → digits 0,1 show '0' (7'h40), digit 2 shows '5', digit 3 is blank.
- Overflow (DIGITS=3): recordTimer=1000 → bcdDigits=12'h999, overflow=1, all three digits show '9' (7'h10).
  - Then recordTimer=42 → next bcdValid gives overflow=0, bcdDigits=12'h042, digit 2 blank.
- Reset mid-conversion: drop resetN for 1 cycle during the 5th SHIFT cycle → no bcdValid, outputs return to reset values.
  - First bcdValid comes 12 edges after release; recordTimer changed during the aborted SHIFT is reflected correctly.

Source files
------------

// File: rtl/chronometer_display.sv
// rtl/chronometer_display.sv - binary count to BCD converter driving a multiplexed 7-segment display
//
// Ports:
//   clk          system clock
//   resetN       synchronous active-low reset
//   recordTimer  binary count from the chronometer, sampled once per conversion
//   bcdDigits    latched BCD result, digit 0 in bits [3:0]
//   bcdValid     one-cycle pulse when bcdDigits/overflow update
//   overflow     high while the shown value is saturated to all nines
//   segments     segment drive {g,f,e,d,c,b,a}
//   anodes       one-hot digit select, bit i drives digit i
module chronometer_display #(
  parameter int FREQ_IN            = 12000000,
  parameter int LIMIT_RECORD_TIMER = 1000,
  parameter int DIGITS             = 4,
  parameter int SCAN_HZ            = 1000,
  parameter int ACTIVE_LOW         = 1,
  parameter int BLANK_LEADING      = 1,
  localparam int IN_W              = $clog2(LIMIT_RECORD_TIMER)
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic [IN_W-1:0]       recordTimer,
  output logic [4*DIGITS-1:0]   bcdDigits,
  output logic                  bcdValid,
  output logic                  overflow,
  output logic [6:0]            segments,
  output logic [DIGITS-1:0]     anodes
);

  // Decimal digits needed for 2^IN_W-1: ceil(IN_W*log10(2)) in fixed point.
  localparam int NB       = (IN_W * 30103 + 99999) / 100000;
  // Keep at least one digit above the display so the saturation test always has bits to look at.
  localparam int NBX      = (NB > DIGITS) ? NB : DIGITS + 1;
  localparam int SCAN_DIV = FREQ_IN / (SCAN_HZ * DIGITS);
  localparam int PW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int XW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW       = $clog2(IN_W + 1);

  localparam logic [6:0]        SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [DIGITS-1:0] AN_OFF  = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                load_en;
  logic                shift_en;
  logic                done_en;
  logic [CW-1:0]       bitcnt;
  logic [IN_W-1:0]     shreg;
  logic [4*NBX-1:0]    bcd;
  logic [4*NBX-1:0]    bcd_adj;
  logic                upper_nz;

  // ---------------------------------------------------------------------------
  // Conversion FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = SHIFT;
      SHIFT:   if (bitcnt == CW'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load_en  = (state == IDLE);
    shift_en = (state == SHIFT);
    done_en  = (state == DONE);
  end

  // Double-dabble correction: any digit that would reach 10+ after the shift is pre-biased by 3.
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < NBX; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end else begin
        bcd_adj[4*i +: 4] = bcd[4*i +: 4];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      shreg  <= '0;
      bcd    <= '0;
      bitcnt <= '0;
    end else if (load_en) begin
      shreg  <= recordTimer;
      bcd    <= '0;
      bitcnt <= CW'(IN_W);
    end else if (shift_en) begin
      {bcd, shreg} <= {bcd_adj, shreg} << 1;
      bitcnt       <= bitcnt - CW'(1);
    end
  end

  assign upper_nz = |bcd[4*NBX-1:4*DIGITS];

  // Result latch: updated on the edge that leaves DONE, together with the valid pulse.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      bcdDigits <= '0;
      overflow  <= 1'b0;
      bcdValid  <= 1'b0;
    end else begin
      bcdValid <= done_en;
      if (done_en) begin
        if (upper_nz) begin
          bcdDigits <= {DIGITS{4'h9}};
          overflow  <= 1'b1;
        end else begin
          bcdDigits <= bcd[4*DIGITS-1:0];
          overflow  <= 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scan prescaler and digit index
  // ---------------------------------------------------------------------------
  logic [PW-1:0] presc;
  logic [XW-1:0] idx;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == PW'(SCAN_DIV - 1)) begin
      presc <= '0;
      idx   <= (idx == XW'(DIGITS - 1)) ? '0 : idx + XW'(1);
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Digit select, leading-zero blanking and decode
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  logic [DIGITS-1:0] zero_from;   // bit i: digit i and all digits above it are zero
  logic [DIGITS-1:0] an_sel;
  logic [3:0]        cur_digit;
  logic              cur_zero;
  logic              cur_blank;
  logic [6:0]        cur_seg;

  always_comb begin
    zero_from = '0;
    zero_from[DIGITS-1] = (bcdDigits[4*DIGITS-1 -: 4] == 4'd0);
    for (int i = DIGITS - 2; i >= 0; i--) begin
      zero_from[i] = zero_from[i+1] && (bcdDigits[4*i +: 4] == 4'd0);
    end

    cur_digit = 4'd0;
    cur_zero  = 1'b0;
    an_sel    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == XW'(i)) begin
        cur_digit = bcdDigits[4*i +: 4];
        cur_zero  = zero_from[i];
        an_sel[i] = 1'b1;
      end
    end

    // Digit 0 is never blanked; a saturated display shows every nine.
    cur_blank = (BLANK_LEADING != 0) && !overflow && (idx != '0) && cur_zero;
    cur_seg   = cur_blank ? 7'h00 : seg7(cur_digit);
  end

  // Segments and anodes share one register stage so they switch on the same edge.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      segments <= SEG_OFF;
      anodes   <= AN_OFF;
    end else begin
      segments <= (ACTIVE_LOW != 0) ? ~cur_seg : cur_seg;
      anodes   <= (ACTIVE_LOW != 0) ? ~an_sel  : an_sel;
    end
  end

endmodule

// File: tb/tb_chronometer_display.sv
// tb/tb_chronometer_display.sv - self-checking bench for chronometer_display (4-digit and 3-digit instances)
module tb_chronometer_display;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic [9:0] recordTimer = '0;

  logic [15:0] bcd4;
  logic        v4, o4;
  logic [6:0]  seg4;
  logic [3:0]  an4;
  logic [11:0] bcd3;
  logic        v3, o3;
  logic [6:0]  seg3;
  logic [2:0]  an3;

  always #5 clk = ~clk;

  chronometer_display #(
    .FREQ_IN(16), .LIMIT_RECORD_TIMER(1000), .DIGITS(4), .SCAN_HZ(1),
    .ACTIVE_LOW(1), .BLANK_LEADING(1)
  ) u4 (
    .clk(clk), .resetN(resetN), .recordTimer(recordTimer),
    .bcdDigits(bcd4), .bcdValid(v4), .overflow(o4), .segments(seg4), .anodes(an4)
  );

  chronometer_display #(
    .FREQ_IN(16), .LIMIT_RECORD_TIMER(1000), .DIGITS(3), .SCAN_HZ(1),
    .ACTIVE_LOW(1), .BLANK_LEADING(1)
  ) u3 (
    .clk(clk), .resetN(resetN), .recordTimer(recordTimer),
    .bcdDigits(bcd3), .bcdValid(v3), .overflow(o3), .segments(seg3), .anodes(an3)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state: edges since reset release, value sampled for the
  // current conversion, value currently latched, value feeding the display this cycle.
  int k = 0;
  int samp = 0;
  int shown = 0;
  int src = 0;
  bit ev = 1'b0;

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  function automatic int p10(int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [23:0] exp_bcd(int v, int nd);
    logic [23:0] r;
    r = '0;
    for (int i = 0; i < nd; i++) begin
      if (v >= p10(nd)) r[4*i +: 4] = 4'd9;
      else              r[4*i +: 4] = 4'((v / p10(i)) % 10);
    end
    return r;
  endfunction

  function automatic logic exp_ovf(int v, int nd);
    return (v >= p10(nd));
  endfunction

  // Active-low pattern expected on digit d of an nd-digit display showing v.
  function automatic logic [6:0] exp_seg(int v, int nd, int d);
    if (v >= p10(nd)) return ~seg_tab[9];
    if (d > 0 && v < p10(d)) return 7'h7F;
    return ~seg_tab[(v / p10(d)) % 10];
  endfunction

  function automatic int exp_an(int nd, int d);
    return ((1 << nd) - 1) & ~(1 << d);
  endfunction

  // One clock edge; outputs are sampled 1 time unit later. Updates the model.
  task automatic tick();
    logic r_at;
    int   v_at;
    r_at = resetN;
    v_at = int'(recordTimer);
    @(posedge clk);
    #1;
    if (!r_at) begin
      k = 0; samp = 0; shown = 0; src = 0; ev = 1'b0;
    end else begin
      k = k + 1;
      src = shown;
      if ((k - 1) % 12 == 0) samp = v_at;
      ev = (k % 12 == 0);
      if (ev) shown = samp;
    end
  endtask

  task automatic start_run(int v);
    recordTimer = 10'(v);
    resetN = 1'b0;
    tick();
    tick();
    resetN = 1'b1;
  endtask

  task automatic test_reset();
    recordTimer = 10'd512;
    resetN = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      tests++;
      if (seg4 !== 7'h7F || an4 !== 4'hF || bcd4 !== 16'h0000 || v4 !== 1'b0 || o4 !== 1'b0) begin
        fails++;
        $display("FAIL reset4 c=%0d got seg=%h an=%b bcd=%h v=%b o=%b exp seg=7f an=1111 bcd=0000 v=0 o=0",
                 c, seg4, an4, bcd4, v4, o4);
      end
      tests++;
      if (seg3 !== 7'h7F || an3 !== 3'h7 || bcd3 !== 12'h000 || v3 !== 1'b0 || o3 !== 1'b0) begin
        fails++;
        $display("FAIL reset3 c=%0d got seg=%h an=%b bcd=%h v=%b o=%b exp seg=7f an=111 bcd=000 v=0 o=0",
                 c, seg3, an3, bcd3, v3, o3);
      end
    end
  endtask

  task automatic test_latency(int v);
    start_run(v);
    for (int c = 0; c < 26; c++) begin
      tick();
      tests++;
      if (v4 !== ev || v3 !== ev) begin
        fails++;
        $display("FAIL latency_valid v=%0d k=%0d got v4=%b v3=%b exp=%b", v, k, v4, v3, ev);
      end
      tests++;
      if (bcd4 !== 16'(exp_bcd(shown, 4)) || o4 !== exp_ovf(shown, 4)) begin
        fails++;
        $display("FAIL latency_bcd4 v=%0d k=%0d got bcd=%h o=%b exp bcd=%h o=%b",
                 v, k, bcd4, o4, 16'(exp_bcd(shown, 4)), exp_ovf(shown, 4));
      end
      tests++;
      if (bcd3 !== 12'(exp_bcd(shown, 3)) || o3 !== exp_ovf(shown, 3)) begin
        fails++;
        $display("FAIL latency_bcd3 v=%0d k=%0d got bcd=%h o=%b exp bcd=%h o=%b",
                 v, k, bcd3, o3, 12'(exp_bcd(shown, 3)), exp_ovf(shown, 3));
      end
    end
  endtask

  task automatic test_scan(int v);
    int d4, d3;
    start_run(v);
    for (int c = 0; c < 60; c++) begin
      tick();
      d4 = ((k - 1) / 4) % 4;
      d3 = ((k - 1) / 5) % 3;
      tests++;
      if (an4 !== 4'(exp_an(4, d4)) || seg4 !== exp_seg(src, 4, d4)) begin
        fails++;
        $display("FAIL scan4 v=%0d k=%0d got an=%b seg=%h exp an=%b seg=%h",
                 v, k, an4, seg4, 4'(exp_an(4, d4)), exp_seg(src, 4, d4));
      end
      tests++;
      if (an3 !== 3'(exp_an(3, d3)) || seg3 !== exp_seg(src, 3, d3)) begin
        fails++;
        $display("FAIL scan3 v=%0d k=%0d got an=%b seg=%h exp an=%b seg=%h",
                 v, k, an3, seg3, 3'(exp_an(3, d3)), exp_seg(src, 3, d3));
      end
    end
  endtask

  task automatic test_overflow();
    int d3;
    start_run(1000);
    for (int c = 0; c < 12; c++) tick();
    tests++;
    if (bcd3 !== 12'h999 || o3 !== 1'b1 || v3 !== 1'b1) begin
      fails++;
      $display("FAIL ovf_set got bcd=%h o=%b v=%b exp bcd=999 o=1 v=1", bcd3, o3, v3);
    end
    tests++;
    if (bcd4 !== 16'h1000 || o4 !== 1'b0) begin
      fails++;
      $display("FAIL ovf_wide got bcd=%h o=%b exp bcd=1000 o=0", bcd4, o4);
    end
    recordTimer = 10'd42;
    for (int c = 0; c < 40; c++) begin
      tick();
      d3 = ((k - 1) / 5) % 3;
      tests++;
      if (o3 !== exp_ovf(shown, 3) || bcd3 !== 12'(exp_bcd(shown, 3)) || v3 !== ev) begin
        fails++;
        $display("FAIL ovf_clear k=%0d got bcd=%h o=%b v=%b exp bcd=%h o=%b v=%b",
                 k, bcd3, o3, v3, 12'(exp_bcd(shown, 3)), exp_ovf(shown, 3), ev);
      end
      tests++;
      if (seg3 !== exp_seg(src, 3, d3)) begin
        fails++;
        $display("FAIL ovf_seg k=%0d digit=%0d got seg=%h exp seg=%h", k, d3, seg3, exp_seg(src, 3, d3));
      end
    end
    tests++;
    if (bcd3 !== 12'h042 || o3 !== 1'b0) begin
      fails++;
      $display("FAIL ovf_final got bcd=%h o=%b exp bcd=042 o=0", bcd3, o3);
    end
  endtask

  task automatic test_reset_mid();
    start_run(300);
    for (int c = 0; c < 3; c++) tick();
    recordTimer = 10'd777;
    tick();
    tick();
    // Edge 6 is taken with resetN low: the 5th SHIFT cycle is aborted.
    resetN = 1'b0;
    tick();
    tests++;
    if (v4 !== 1'b0 || seg4 !== 7'h7F || an4 !== 4'hF || bcd4 !== 16'h0000 || o4 !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset got v=%b seg=%h an=%b bcd=%h o=%b exp v=0 seg=7f an=1111 bcd=0000 o=0",
               v4, seg4, an4, bcd4, o4);
    end
    resetN = 1'b1;
    for (int c = 0; c < 13; c++) begin
      tick();
      tests++;
      if (v4 !== ev || v3 !== ev) begin
        fails++;
        $display("FAIL mid_valid k=%0d got v4=%b v3=%b exp=%b", k, v4, v3, ev);
      end
      tests++;
      if (bcd4 !== 16'(exp_bcd(shown, 4))) begin
        fails++;
        $display("FAIL mid_bcd k=%0d got bcd=%h exp bcd=%h", k, bcd4, 16'(exp_bcd(shown, 4)));
      end
    end
    tests++;
    if (bcd4 !== 16'h0777) begin
      fails++;
      $display("FAIL mid_final got bcd=%h exp bcd=0777", bcd4);
    end
  endtask

  // Input changes every cycle; only values present at load edges may appear.
  task automatic test_back_to_back();
    start_run(int'($urandom_range(0, 1023)));
    for (int c = 0; c < 120; c++) begin
      recordTimer = 10'($urandom_range(0, 1023));
      tick();
      tests++;
      if (v4 !== ev || bcd4 !== 16'(exp_bcd(shown, 4)) || o4 !== exp_ovf(shown, 4)) begin
        fails++;
        $display("FAIL b2b4 k=%0d got v=%b bcd=%h o=%b exp v=%b bcd=%h o=%b",
                 k, v4, bcd4, o4, ev, 16'(exp_bcd(shown, 4)), exp_ovf(shown, 4));
      end
      tests++;
      if (v3 !== ev || bcd3 !== 12'(exp_bcd(shown, 3)) || o3 !== exp_ovf(shown, 3)) begin
        fails++;
        $display("FAIL b2b3 k=%0d got v=%b bcd=%h o=%b exp v=%b bcd=%h o=%b",
                 k, v3, bcd3, o3, ev, 12'(exp_bcd(shown, 3)), exp_ovf(shown, 3));
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency(987);
    test_latency(0);
    test_latency(1);
    test_latency(1023);
    for (int r = 0; r < 3; r++) test_latency(int'($urandom_range(0, 1023)));
    test_scan(1023);
    test_scan(5);
    test_scan(500);
    test_scan(1000);
    for (int r = 0; r < 2; r++) test_scan(int'($urandom_range(0, 1023)));
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
